// File: rtl/pwr_stim_gen_pkg.sv
// Shared encodings and LFSR helper for the power-characterisation stimulus generator.
package pwr_stim_gen_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LFSR_W = 16;

  // Fibonacci taps at bits 15, 13, 12 and 10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_COUNT  = 2'b01,
    MODE_LFSR   = 2'b10,
    MODE_WALK   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pwr_stim_lfsr16.sv
// 16-bit Fibonacci LFSR with load and step; an all-zero seed is replaced by 1.
module pwr_stim_lfsr16
  import pwr_stim_gen_pkg::*;
#(
  parameter int unsigned       WIDTH = 4,
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] vec_c
);

  localparam logic [LFSR_W-1:0] SEED_FIX = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] base_c;

  // On a load cycle the seed itself is the vector being emitted
  assign base_c = load ? SEED_FIX : lfsr_q;
  assign vec_c  = base_c[WIDTH-1:0];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      lfsr_q <= SEED_FIX;
    end else if (step) begin
      lfsr_q <= lfsr_next(base_c);
    end else if (load) begin
      lfsr_q <= SEED_FIX;
    end
  end

endmodule

// File: rtl/pwr_stim_gen.sv
// Stimulus generator for a combinational cell under power characterisation;
// emits NUM_VEC pattern vectors per run and counts toggles on the cell output.
module pwr_stim_gen
  import pwr_stim_gen_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_VEC = 256,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic             obs,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vcnt,
  output logic [CNT_W-1:0] togcnt
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             obs_q;
  logic [WIDTH-1:0] out_d;
  logic             valid_d, busy_d, done_d;
  logic [CNT_W-1:0] vcnt_d, tog_d;
  logic             lfsr_load_c, lfsr_step_c, run_end_c;
  logic [WIDTH-1:0] lfsr_vec_c;

  assign run_end_c   = stop || (vcnt == CNT_W'(NUM_VEC));
  assign lfsr_load_c = start && (state_q != ST_RUN);
  assign lfsr_step_c = lfsr_load_c || ((state_q == ST_RUN) && !run_end_c);

  pwr_stim_lfsr16 #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rstb  (rstb),
    .load  (lfsr_load_c),
    .step  (lfsr_step_c),
    .vec_c (lfsr_vec_c)
  );

  // Next vector derived from the previous one, so no modulo hardware is needed
  function automatic logic [WIDTH-1:0] next_vec(input mode_e            m,
                                                input logic             first,
                                                input logic [WIDTH-1:0] prev,
                                                input logic [WIDTH-1:0] lv);
    logic [WIDTH-1:0] v;
    v = '0;
    case (m)
      MODE_STATIC: v = '0;
      MODE_COUNT:  v = first ? '0 : prev + WIDTH'(1);
      MODE_LFSR:   v = lv;
      MODE_WALK:   v = first ? WIDTH'(1) : ((prev << 1) | (prev >> (WIDTH - 1)));
      default:     v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    out_d   = out;
    valid_d = valid;
    busy_d  = busy;
    done_d  = done;
    vcnt_d  = vcnt;
    tog_d   = togcnt;

    if (busy && (obs != obs_q) && (togcnt != '1)) begin
      tog_d = togcnt + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          out_d   = next_vec(mode_e'(mode), 1'b1, out, lfsr_vec_c);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          vcnt_d  = CNT_W'(1);
          tog_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // OUT is left untouched on exit so the cell sees no extra transition
        if (run_end_c) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          out_d  = next_vec(mode_q, 1'b0, out, lfsr_vec_c);
          vcnt_d = vcnt + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_STATIC;
      obs_q   <= 1'b0;
      out     <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      vcnt    <= '0;
      togcnt  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      obs_q   <= obs;
      out     <= out_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
      vcnt    <= vcnt_d;
      togcnt  <= tog_d;
    end
  end

endmodule

// File: tb/tb_pwr_stim_gen.sv
// Self-checking bench for pwr_stim_gen: three parameterisations against a
// behavioural pattern/toggle model with randomized OBS and run options.
module tb_pwr_stim_gen;

  localparam int W_A = 4;
  localparam int N_A = 16;
  localparam int W_B = 4;
  localparam int N_B = 6;
  localparam int W_C = 1;
  localparam int N_C = 65535;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: general tests
  logic           start_a = 1'b0, stop_a = 1'b0, obs_rnd_a = 1'b0, follow_a = 1'b0;
  logic [1:0]     mode_a = 2'b00;
  logic           obs_a;
  logic [W_A-1:0] out_a;
  logic           valid_a, busy_a, done_a;
  logic [15:0]    vcnt_a, togcnt_a;
  logic           edge_obs_a = 1'b0;
  assign obs_a = follow_a ? out_a[0] : obs_rnd_a;

  pwr_stim_gen #(.WIDTH(W_A), .NUM_VEC(N_A), .SEED(16'hACE1)) dut_a (
    .clk(clk), .rstb(rstb), .start(start_a), .stop(stop_a), .mode(mode_a), .obs(obs_a),
    .out(out_a), .valid(valid_a), .busy(busy_a), .done(done_a), .vcnt(vcnt_a), .togcnt(togcnt_a));

  // Instance B: short runs, zero seed
  logic           start_b = 1'b0, stop_b = 1'b0, obs_b = 1'b0;
  logic [1:0]     mode_b = 2'b00;
  logic [W_B-1:0] out_b;
  logic           valid_b, busy_b, done_b;
  logic [15:0]    vcnt_b, togcnt_b;

  pwr_stim_gen #(.WIDTH(W_B), .NUM_VEC(N_B), .SEED(16'h0000)) dut_b (
    .clk(clk), .rstb(rstb), .start(start_b), .stop(stop_b), .mode(mode_b), .obs(obs_b),
    .out(out_b), .valid(valid_b), .busy(busy_b), .done(done_b), .vcnt(vcnt_b), .togcnt(togcnt_b));

  // Instance C: maximum-length run for counter saturation
  logic           start_c = 1'b0, stop_c = 1'b0, obs_c = 1'b0;
  logic [1:0]     mode_c = 2'b00;
  logic [W_C-1:0] out_c;
  logic           valid_c, busy_c, done_c;
  logic [15:0]    vcnt_c, togcnt_c;

  pwr_stim_gen #(.WIDTH(W_C), .NUM_VEC(N_C), .SEED(16'hACE1)) dut_c (
    .clk(clk), .rstb(rstb), .start(start_c), .stop(stop_c), .mode(mode_c), .obs(obs_c),
    .out(out_c), .valid(valid_c), .busy(busy_c), .done(done_c), .vcnt(vcnt_c), .togcnt(togcnt_c));

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Expected vector k of a run, straight from the pattern definitions
  function automatic int exp_vec(input int m, input int k, input int w, input logic [15:0] seed);
    logic [15:0] l;
    l = (seed == 16'h0) ? 16'h0001 : seed;
    case (m)
      0: return 0;
      1: return k % (1 << w);
      2: begin
        for (int i = 0; i < k; i++) l = lfsr_step(l);
        return int'(l) & ((1 << w) - 1);
      end
      default: return 1 << (k % w);
    endcase
  endfunction

  // One clock on instance A; reports whether OBS at this edge differs from the last edge
  task automatic step_a(output bit toggled);
    logic o;
    obs_rnd_a = 1'($urandom_range(0, 1));
    #1;
    o = obs_a;
    @(posedge clk);
    #1;
    toggled    = (o != edge_obs_a);
    edge_obs_a = o;
  endtask

  task automatic run_a(input int m, input int stop_k, input int start_k, input bit both,
                       input bit follow, input string name);
    int ev[N_A];
    int n, exp_tog;
    bit tg, fin;
    for (int k = 0; k < N_A; k++) ev[k] = exp_vec(m, k, W_A, 16'hACE1);
    follow_a = follow;
    mode_a   = 2'(m);
    start_a  = 1'b1;
    stop_a   = both;
    step_a(tg);
    start_a = 1'b0;
    stop_a  = 1'b0;
    mode_a  = 2'($urandom_range(0, 3));
    checks++;
    if (out_a !== W_A'(ev[0]) || valid_a !== 1'b1 || busy_a !== 1'b1 || done_a !== 1'b0 ||
        vcnt_a !== 16'd1 || togcnt_a !== 16'd0) begin
      errors++;
      $display("FAIL %s vec0: out=%h valid=%b busy=%b done=%b vcnt=%0d tog=%0d, expected out=%h valid=1 busy=1 done=0 vcnt=1 tog=0",
               name, out_a, valid_a, busy_a, done_a, vcnt_a, togcnt_a, W_A'(ev[0]));
    end
    n = 1; exp_tog = 0; fin = 1'b0;
    for (int cyc = 0; cyc < N_A + 4 && !fin; cyc++) begin
      stop_a  = (n - 1 == stop_k);
      start_a = (n == start_k);
      step_a(tg);
      if (tg) exp_tog++;
      if (stop_a || n == N_A) begin
        fin = 1'b1;
        checks++;
        if (out_a !== W_A'(ev[n-1]) || valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b1 ||
            vcnt_a !== 16'(n) || togcnt_a !== 16'(exp_tog)) begin
          errors++;
          $display("FAIL %s end: out=%h valid=%b busy=%b done=%b vcnt=%0d tog=%0d, expected out=%h valid=0 busy=0 done=1 vcnt=%0d tog=%0d",
                   name, out_a, valid_a, busy_a, done_a, vcnt_a, togcnt_a, W_A'(ev[n-1]), n, exp_tog);
        end
      end else begin
        checks++;
        if (out_a !== W_A'(ev[n]) || valid_a !== 1'b1 || busy_a !== 1'b1 || done_a !== 1'b0 ||
            vcnt_a !== 16'(n + 1) || togcnt_a !== 16'(exp_tog)) begin
          errors++;
          $display("FAIL %s vec%0d: out=%h valid=%b busy=%b done=%b vcnt=%0d tog=%0d, expected out=%h valid=1 busy=1 done=0 vcnt=%0d tog=%0d",
                   name, n, out_a, valid_a, busy_a, done_a, vcnt_a, togcnt_a, W_A'(ev[n]), n + 1, exp_tog);
        end
        n++;
      end
    end
    start_a = 1'b0;
    stop_a  = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: run still busy after %0d cycles, required end by %0d", name, N_A + 4, N_A);
    end
    step_a(tg);
    checks++;
    if (out_a !== W_A'(ev[n-1]) || valid_a !== 1'b0 || done_a !== 1'b1 || vcnt_a !== 16'(n) ||
        togcnt_a !== 16'(exp_tog)) begin
      errors++;
      $display("FAIL %s hold: out=%h valid=%b done=%b vcnt=%0d tog=%0d, expected out=%h valid=0 done=1 vcnt=%0d tog=%0d",
               name, out_a, valid_a, done_a, vcnt_a, togcnt_a, W_A'(ev[n-1]), n, exp_tog);
    end
  endtask

  task automatic test_reset;
    bit tg;
    #3;
    checks++;
    if (out_a !== '0 || valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 ||
        vcnt_a !== 16'd0 || togcnt_a !== 16'd0 || out_c !== '0 || vcnt_c !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: out=%h valid=%b busy=%b done=%b vcnt=%0d tog=%0d, expected all 0",
               out_a, valid_a, busy_a, done_a, vcnt_a, togcnt_a);
    end
    @(negedge clk);
    rstb       = 1'b1;
    edge_obs_a = 1'b0;
    step_a(tg);
    checks++;
    if (out_a !== '0 || valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || vcnt_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_idle: out=%h valid=%b busy=%b done=%b vcnt=%0d, expected all 0",
               out_a, valid_a, busy_a, done_a, vcnt_a);
    end
  endtask

  task automatic test_reset_midrun;
    bit tg;
    follow_a = 1'b1;
    mode_a   = 2'b01;
    start_a  = 1'b1;
    step_a(tg);
    start_a = 1'b0;
    for (int i = 0; i < 5; i++) step_a(tg);
    checks++;
    if (out_a !== 4'd5 || vcnt_a !== 16'd6) begin
      errors++;
      $display("FAIL midrun_pre: out=%h vcnt=%0d, expected out=5 vcnt=6", out_a, vcnt_a);
    end
    #2;
    rstb = 1'b0;
    #1;
    checks++;
    if (out_a !== '0 || valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 ||
        vcnt_a !== 16'd0 || togcnt_a !== 16'd0) begin
      errors++;
      $display("FAIL midrun_async_reset: out=%h valid=%b busy=%b done=%b vcnt=%0d tog=%0d, expected all 0",
               out_a, valid_a, busy_a, done_a, vcnt_a, togcnt_a);
    end
    @(negedge clk);
    @(negedge clk);
    rstb       = 1'b1;
    edge_obs_a = 1'b0;
    step_a(tg);
    step_a(tg);
    checks++;
    if (out_a !== '0 || valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || vcnt_a !== 16'd0) begin
      errors++;
      $display("FAIL midrun_idle_after: out=%h valid=%b busy=%b done=%b vcnt=%0d, expected all 0",
               out_a, valid_a, busy_a, done_a, vcnt_a);
    end
  endtask

  task automatic test_count;
    run_a(1, -1, -1, 1'b0, 1'b1, "count");
    checks++;
    if (out_a !== 4'd15 || vcnt_a !== 16'd16 || togcnt_a !== 16'd15) begin
      errors++;
      $display("FAIL count_summary: out=%0d vcnt=%0d tog=%0d, expected out=15 vcnt=16 tog=15", out_a, vcnt_a, togcnt_a);
    end
  endtask

  task automatic test_lfsr;
    run_a(2, -1, -1, 1'b0, 1'b0, "lfsr");
  endtask

  task automatic test_stop;
    run_a(1, 3, -1, 1'b0, 1'b0, "stop");
    checks++;
    if (vcnt_a !== 16'd4 || out_a !== 4'd3) begin
      errors++;
      $display("FAIL stop_summary: vcnt=%0d out=%0d, expected vcnt=4 out=3", vcnt_a, out_a);
    end
  endtask

  task automatic test_start_in_run;
    run_a(3, -1, 7, 1'b0, 1'b0, "start_in_run");
    checks++;
    if (vcnt_a !== 16'd16) begin
      errors++;
      $display("FAIL start_in_run_len: vcnt=%0d, expected 16", vcnt_a);
    end
  endtask

  task automatic test_start_stop_fin;
    run_a(1, -1, -1, 1'b1, 1'b1, "start_stop_fin");
  endtask

  task automatic test_random;
    int m, sk, st;
    for (int i = 0; i < 8; i++) begin
      m  = int'($urandom_range(0, 3));
      sk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 14)) : -1;
      st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : -1;
      run_a(m, sk, st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic run_b(input int m, input string name);
    int ev;
    mode_b  = 2'(m);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    for (int k = 0; k < N_B; k++) begin
      ev = exp_vec(m, k, W_B, 16'h0000);
      checks++;
      if (out_b !== W_B'(ev) || valid_b !== 1'b1 || vcnt_b !== 16'(k + 1)) begin
        errors++;
        $display("FAIL %s vec%0d: out=%h valid=%b vcnt=%0d, expected out=%h valid=1 vcnt=%0d",
                 name, k, out_b, valid_b, vcnt_b, W_B'(ev), k + 1);
      end
      @(posedge clk);
      #1;
    end
    ev = exp_vec(m, N_B - 1, W_B, 16'h0000);
    checks++;
    if (out_b !== W_B'(ev) || valid_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b1 ||
        vcnt_b !== 16'(N_B) || togcnt_b !== 16'd0) begin
      errors++;
      $display("FAIL %s end: out=%h valid=%b busy=%b done=%b vcnt=%0d tog=%0d, expected out=%h valid=0 busy=0 done=1 vcnt=%0d tog=0",
               name, out_b, valid_b, busy_b, done_b, vcnt_b, togcnt_b, W_B'(ev), N_B);
    end
  endtask

  task automatic test_walk;
    run_b(3, "walk");
    checks++;
    if (out_b !== 4'd2) begin
      errors++;
      $display("FAIL walk_final: out=%h, expected 2", out_b);
    end
  endtask

  task automatic test_seed0;
    run_b(2, "lfsr_seed0");
  endtask

  task automatic test_saturation;
    int k, bad, cycles;
    mode_c  = 2'b01;
    start_c = 1'b1;
    obs_c   = ~obs_c;
    @(posedge clk);
    #1;
    start_c = 1'b0;
    k = 0; bad = 0; cycles = 0;
    while (!done_c && cycles < 70000) begin
      if (valid_c) begin
        if (out_c !== 1'(k % 2)) bad++;
        k++;
      end
      obs_c = ~obs_c;
      @(posedge clk);
      #1;
      cycles++;
    end
    checks++;
    if (done_c !== 1'b1 || k != N_C || bad != 0) begin
      errors++;
      $display("FAIL sat_run: done=%b vectors=%0d bad_vectors=%0d, expected done=1 vectors=%0d bad_vectors=0",
               done_c, k, bad, N_C);
    end
    checks++;
    if (vcnt_c !== 16'hFFFF || togcnt_c !== 16'hFFFF || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL sat_counts: vcnt=%h tog=%h busy=%b, expected vcnt=ffff tog=ffff busy=0", vcnt_c, togcnt_c, busy_c);
    end
    for (int i = 0; i < 4; i++) begin
      obs_c = ~obs_c;
      @(posedge clk);
      #1;
    end
    checks++;
    if (togcnt_c !== 16'hFFFF || vcnt_c !== 16'hFFFF || out_c !== 1'b0) begin
      errors++;
      $display("FAIL sat_hold: tog=%h vcnt=%h out=%b, expected tog=ffff vcnt=ffff out=0", togcnt_c, vcnt_c, out_c);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_count();
    test_lfsr();
    test_stop();
    test_start_in_run();
    test_start_stop_fin();
    test_random();
    test_walk();
    test_seed0();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1);
  end

endmodule
